count_monitor: RTL and testbench



---
 rtl/count_monitor_if.sv | 25 ++
 rtl/count_monitor.sv | 135 +++++++++++++
 tb/tb_count_monitor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/count_monitor_if.sv
// count_monitor_if: bundles the sampled counter value, the error-clear request
// and every monitor result. The master modport is the side that feeds the
// monitor and observes its results. The slave modport is the monitor itself.
interface count_monitor_if #(
    parameter int WRAP_W = 8
);
    logic [3:0]        q_counter;
    logic              clr_err;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              seq_err;
    logic              err_sticky;
    logic [7:0]        err_count;

    modport master (
        output q_counter, clr_err,
        input  locked, wrap_pulse, wrap_count, seq_err, err_sticky, err_count
    );

    modport slave (
        input  q_counter, clr_err,
        output locked, wrap_pulse, wrap_count, seq_err, err_sticky, err_count
    );
endinterface

// File: rtl/count_monitor.sv
// count_monitor: checks a 4-bit free-running counter stream for the +1 mod 16
// sequence. It locks after LOCK_N consecutive good steps. While locked it
// pulses on each 15->0 wrap and tallies wraps. A sequence break while locked
// pulses seq_err and sets a sticky flag. All outputs are registered, so each
// result appears one cycle after the edge that sampled its cause.
// Optional feature: define COUNT_MONITOR_ERRCNT_EN to build a saturating
// violation counter on err_count. Without the macro, err_count is tied to 0.
module count_monitor #(
    parameter int LOCK_N = 4,
    parameter int WRAP_W = 8
) (
    input  logic           clock,
    input  logic           rst,
    count_monitor_if.slave mon
);
    typedef enum logic [1:0] {SYNC, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    state_t            state, state_nxt;
    logic [3:0]        prev;
    logic [3:0]        prev_inc;
    logic [3:0]        run, run_nxt;
    logic              good;
    logic              violation;
    logic              wrap;

    logic              locked_r;
    logic              wrap_pulse_r;
    logic [WRAP_W-1:0] wrap_count_r;
    logic              seq_err_r;
    logic              err_sticky_r;

    // A held value is not a +1 step, so it counts as a violation too
    assign prev_inc = prev + 4'd1;
    assign good     = (mon.q_counter == prev_inc);

    // Next-state logic and detection of wrap and violation events
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        violation = 1'b0;
        wrap      = 1'b0;
        case (state)
            SYNC: begin
                // The first sample only seeds prev; it has nothing to compare against
                state_nxt = ACQUIRE;
                run_nxt   = 4'd0;
            end
            ACQUIRE: begin
                if (good) begin
                    run_nxt = run + 4'd1;
                    if (run_nxt == LOCK_V) begin
                        state_nxt = LOCKED;
                    end
                end else begin
                    run_nxt = 4'd0;
                end
            end
            LOCKED: begin
                if (good) begin
                    wrap = (prev == 4'd15);
                end else begin
                    violation = 1'b1;
                    state_nxt = ACQUIRE;
                    run_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = SYNC;
                run_nxt   = 4'd0;
            end
        endcase
    end

    // State, sample history and registered results
    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= SYNC;
            prev         <= 4'd0;
            run          <= 4'd0;
            locked_r     <= 1'b0;
            wrap_pulse_r <= 1'b0;
            wrap_count_r <= '0;
            seq_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev         <= mon.q_counter;
            run          <= run_nxt;
            locked_r     <= (state_nxt == LOCKED);
            wrap_pulse_r <= wrap;
            seq_err_r    <= violation;
            if (wrap) begin
                wrap_count_r <= wrap_count_r + WRAP_W'(1);
            end
            // A new violation outranks a clear request on the same edge
            if (violation) begin
                err_sticky_r <= 1'b1;
            end else if (mon.clr_err) begin
                err_sticky_r <= 1'b0;
            end
        end
    end

    assign mon.locked     = locked_r;
    assign mon.wrap_pulse = wrap_pulse_r;
    assign mon.wrap_count = wrap_count_r;
    assign mon.seq_err    = seq_err_r;
    assign mon.err_sticky = err_sticky_r;

`ifdef COUNT_MONITOR_ERRCNT_EN
    logic [7:0] err_count_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating violation tally; a violation on a clear edge restarts it at 1
    always_ff @(posedge clock) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if (violation) begin
            err_count_r <= mon.clr_err ? 8'd1 : sat_inc(err_count_r);
        end else if (mon.clr_err) begin
            err_count_r <= 8'd0;
        end
    end

    assign mon.err_count = err_count_r;
`else
    assign mon.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: table-driven bench for count_monitor (LOCK_N=4, WRAP_W=8).
// Each record holds one edge's inputs and the outputs expected after that edge.
// Records go into a scoreboard queue when driven and are popped for comparison
// #1 after the rising edge.
module tb_count_monitor;
    typedef struct {
        logic [3:0] q;
        logic       clr;
        logic       r;
        logic       lk;
        logic       wp;
        logic [7:0] wc;
        logic       se;
        logic       st;
        logic [7:0] ec;
    } vec_t;

    logic clock;
    logic rst;

    count_monitor_if #(.WRAP_W(8)) bus ();

    count_monitor #(.LOCK_N(4), .WRAP_W(8)) dut (
        .clock (clock),
        .rst   (rst),
        .mon   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] exp_wc = 8'd0;
    logic       exp_st = 1'b0;
    logic [7:0] exp_ec = 8'd0;

    // Append one edge: inputs plus hand-specified lock/wrap/error expectations;
    // the tallies follow from the events declared here.
    task automatic add_vec(input logic [3:0] q, input logic clr, input logic r,
                           input logic lk, input logic wp, input logic se);
        vec_t v;
        if (r) begin
            exp_wc = 8'd0;
            exp_st = 1'b0;
            exp_ec = 8'd0;
        end else begin
            if (wp) exp_wc = exp_wc + 8'd1;
            if (se) begin
                exp_st = 1'b1;
`ifdef COUNT_MONITOR_ERRCNT_EN
                if (clr) exp_ec = 8'd1;
                else if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
`endif
            end else if (clr) begin
                exp_st = 1'b0;
                exp_ec = 8'd0;
            end
        end
        v.q = q; v.clr = clr; v.r = r;
        v.lk = lk; v.wp = wp; v.wc = exp_wc;
        v.se = se; v.st = exp_st; v.ec = exp_ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        bus.q_counter = 4'd0;
        bus.clr_err = 1'b0;

        // Reset, then an ideal counter from 0: lock after e5, wraps at e17/e33/e49
        add_vec(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            logic [3:0] q;
            q = 4'((k - 1) % 16);
            add_vec(q, 1'b0, 1'b0, k >= 5, (k >= 17) && (q == 4'd0), 1'b0);
        end

        // Continue ideal to 6 (one more wrap), then jump 6->9 and re-lock
        for (int q = 12; q <= 15; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int q = 1; q <= 6; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int q = 10; q <= 12; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Run to 7 through a wrap, then hold 7 for two edges
        add_vec(4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int q = 1; q <= 7; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int q = 8; q <= 10; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Plain clear, new violation, re-lock, then clear coinciding with a violation
        add_vec(4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int q = 6; q <= 8; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int q = 4; q <= 6; q++) add_vec(4'(q), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while locked with a non-zero wrap tally, then re-lock from 0
        add_vec(4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) add_vec(4'(k - 1), 1'b0, 1'b0, k >= 5, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            bus.q_counter = vecs[i].q;
            bus.clr_err   = vecs[i].clr;
            rst           = vecs[i].r;
            sb.push_back(vecs[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk("locked",     i, {7'd0, bus.locked},     {7'd0, e.lk});
            chk("wrap_pulse", i, {7'd0, bus.wrap_pulse}, {7'd0, e.wp});
            chk("wrap_count", i, bus.wrap_count,         e.wc);
            chk("seq_err",    i, {7'd0, bus.seq_err},    {7'd0, e.se});
            chk("err_sticky", i, {7'd0, bus.err_sticky}, {7'd0, e.st});
            chk("err_count",  i, bus.err_count,          e.ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
